rv_slot_allocator: RTL and testbench

- Companion to the combinational first-valid selector.
- The selector gathers N tagged inputs down to one output. This block does the reverse: it scatters a single incoming item into the first free of N storage slots and returns the slot index to the requester.
- Slots are held until explicitly released.
- Used for tag/index allocation, e.g. per-warp pending-request buffers in the GPU pipeline.

---
 rtl/rv_slot_allocator.sv | 84 ++++++++
 tb/tb_rv_slot_allocator.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rv_slot_allocator.sv
// Scatters incoming items into the first free of N slots and returns the slot index.
// Slots stay occupied until released; released slots keep stale data.
module rv_slot_allocator #(
    parameter int N       = 4,
    parameter int DATAW   = 2,
    parameter bit REVERSE = 1'b0,
    localparam int IDXW   = (N <= 2) ? 1 : $clog2(N),
    localparam int CNTW   = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             acquire_valid,
    input  logic [DATAW-1:0] acquire_data,
    output logic             acquire_ready,
    output logic [IDXW-1:0]  acquire_idx,
    input  logic             release_valid,
    input  logic [IDXW-1:0]  release_idx,
    input  logic [IDXW-1:0]  read_idx,
    output logic [DATAW-1:0] read_data,
    output logic             read_used,
    output logic [CNTW-1:0]  count,
    output logic             empty,
    output logic             full
);

    localparam logic [IDXW:0] NV = (IDXW + 1)'(N);

    logic [N-1:0]     used;
    logic [DATAW-1:0] data [N];
    logic [IDXW-1:0]  free_idx;
    logic             fire;
    logic             rel_ok;
    logic             rel_eff;
    logic             rd_ok;

    // Later assignments win, so the scan direction picks lowest or highest.
    always_comb begin
        free_idx = '0;
        if (REVERSE) begin
            for (int i = 0; i < N; i++) begin
                if (!used[i]) free_idx = IDXW'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (!used[i]) free_idx = IDXW'(i);
            end
        end
    end

    assign full          = (count == CNTW'(N));
    assign empty         = (count == '0);
    assign acquire_ready = !full;
    assign acquire_idx   = free_idx;

    assign fire    = acquire_valid && acquire_ready;
    assign rel_ok  = ({1'b0, release_idx} < NV);
    assign rel_eff = release_valid && rel_ok && used[release_idx];

    assign rd_ok     = ({1'b0, read_idx} < NV);
    assign read_used = rd_ok && used[read_idx];
    assign read_data = rd_ok ? data[read_idx] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            used  <= '0;
            data  <= '{default: '0};
            count <= '0;
        end else begin
            if (fire) begin
                used[free_idx] <= 1'b1;
                data[free_idx] <= acquire_data;
            end
            if (rel_eff) begin
                used[release_idx] <= 1'b0;
            end
            if (fire && !rel_eff) begin
                count <= count + CNTW'(1);
            end else if (!fire && rel_eff) begin
                count <= count - CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rv_slot_allocator.sv
// Directed bench for rv_slot_allocator: N=4 lowest-first table, N=5 highest-first sequence.
module tb_rv_slot_allocator;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A: N=4, DATAW=2, REVERSE=0
    logic       a_av, a_rv, a_rdy, a_ru, a_full, a_empty;
    logic [1:0] a_ad, a_ri, a_rdi, a_idx, a_rd;
    logic [2:0] a_cnt;

    // Instance B: N=5, DATAW=2, REVERSE=1
    logic       b_av, b_rv, b_rdy, b_ru, b_full, b_empty;
    logic [1:0] b_ad, b_rd;
    logic [2:0] b_ri, b_rdi, b_idx, b_cnt;

    rv_slot_allocator #(.N(4), .DATAW(2), .REVERSE(1'b0)) dut_a (
        .clk(clk), .reset(reset),
        .acquire_valid(a_av), .acquire_data(a_ad),
        .acquire_ready(a_rdy), .acquire_idx(a_idx),
        .release_valid(a_rv), .release_idx(a_ri),
        .read_idx(a_rdi), .read_data(a_rd), .read_used(a_ru),
        .count(a_cnt), .empty(a_empty), .full(a_full)
    );

    rv_slot_allocator #(.N(5), .DATAW(2), .REVERSE(1'b1)) dut_b (
        .clk(clk), .reset(reset),
        .acquire_valid(b_av), .acquire_data(b_ad),
        .acquire_ready(b_rdy), .acquire_idx(b_idx),
        .release_valid(b_rv), .release_idx(b_ri),
        .read_idx(b_rdi), .read_data(b_rd), .read_used(b_ru),
        .count(b_cnt), .empty(b_empty), .full(b_full)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit       av;
        bit [1:0] ad;
        bit       rv;
        bit [1:0] ri;
        bit [1:0] rdi;
        bit       rdy;
        bit [1:0] idx;
        bit [1:0] rd;
        bit       ru;
        bit [2:0] cnt;
        bit       fl;
        bit       em;
    } vec_t;

    vec_t vt [15];

    task automatic step_b(input bit av, input bit [1:0] ad, input bit rv,
                          input bit [2:0] ri, input bit [2:0] rdi);
        @(negedge clk);
        b_av = av; b_ad = ad; b_rv = rv; b_ri = ri; b_rdi = rdi;
        #1;
    endtask

    initial begin
        // Expected values are the pre-edge outputs for that cycle's inputs.
        //          av ad rv ri rdi rdy idx rd ru cnt fl em
        vt[0]  = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        vt[1]  = '{1, 2, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0};
        vt[2]  = '{1, 3, 0, 0, 1, 1, 2, 2, 1, 2, 0, 0};
        vt[3]  = '{1, 0, 0, 0, 2, 1, 3, 3, 1, 3, 0, 0};
        vt[4]  = '{0, 0, 0, 0, 2, 0, 0, 3, 1, 4, 1, 0};
        vt[5]  = '{1, 1, 0, 0, 3, 0, 0, 0, 1, 4, 1, 0};
        vt[6]  = '{0, 0, 1, 1, 1, 0, 0, 2, 1, 4, 1, 0};
        vt[7]  = '{1, 2, 0, 0, 1, 1, 1, 2, 0, 3, 0, 0};
        vt[8]  = '{0, 0, 0, 0, 1, 0, 0, 2, 1, 4, 1, 0};
        vt[9]  = '{0, 0, 1, 2, 2, 0, 0, 3, 1, 4, 1, 0};
        vt[10] = '{0, 0, 1, 3, 2, 1, 2, 3, 0, 3, 0, 0};
        vt[11] = '{0, 0, 1, 3, 3, 1, 2, 0, 0, 2, 0, 0};
        vt[12] = '{1, 1, 1, 0, 0, 1, 2, 1, 1, 2, 0, 0};
        vt[13] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 2, 0, 0};
        vt[14] = '{0, 0, 0, 0, 2, 1, 0, 1, 1, 2, 0, 0};

        reset = 1'b0;
        a_av = 0; a_ad = 0; a_rv = 0; a_ri = 0; a_rdi = 0;
        b_av = 0; b_ad = 0; b_rv = 0; b_ri = 0; b_rdi = 0;
        #1;
        chk("a_rst_ready", a_rdy, 1);
        chk("a_rst_idx", a_idx, 0);
        chk("a_rst_empty", a_empty, 1);
        chk("a_rst_full", a_full, 0);
        chk("a_rst_cnt", a_cnt, 0);
        chk("a_rst_rd", a_rd, 0);
        chk("a_rst_ru", a_ru, 0);
        chk("b_rst_idx", b_idx, 4);
        chk("b_rst_ready", b_rdy, 1);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            a_av = vt[i].av; a_ad = vt[i].ad;
            a_rv = vt[i].rv; a_ri = vt[i].ri; a_rdi = vt[i].rdi;
            #1;
            chk($sformatf("v%0d_ready", i), a_rdy, vt[i].rdy);
            chk($sformatf("v%0d_idx", i), a_idx, vt[i].idx);
            chk($sformatf("v%0d_rdata", i), a_rd, vt[i].rd);
            chk($sformatf("v%0d_rused", i), a_ru, vt[i].ru);
            chk($sformatf("v%0d_count", i), a_cnt, vt[i].cnt);
            chk($sformatf("v%0d_full", i), a_full, vt[i].fl);
            chk($sformatf("v%0d_empty", i), a_empty, vt[i].em);
        end
        @(negedge clk);
        a_av = 0; a_rv = 0;

        // Highest-first allocation on N=5
        step_b(1, 1, 0, 0, 0);
        chk("b_acq0_idx", b_idx, 4);
        step_b(1, 2, 0, 0, 4);
        chk("b_acq1_idx", b_idx, 3);
        chk("b_rd4", b_rd, 1);
        step_b(1, 3, 0, 0, 3);
        chk("b_acq2_idx", b_idx, 2);
        chk("b_rd3", b_rd, 2);
        step_b(0, 0, 1, 3, 2);
        chk("b_cnt3", b_cnt, 3);
        chk("b_rd2", b_rd, 3);
        chk("b_idx_before_rel", b_idx, 1);
        step_b(1, 0, 0, 0, 3);
        chk("b_reacq_idx", b_idx, 3);
        chk("b_cnt2", b_cnt, 2);
        chk("b_ru3_free", b_ru, 0);
        step_b(0, 0, 1, 5, 3);
        chk("b_ru3_used", b_ru, 1);
        chk("b_rd3_new", b_rd, 0);
        step_b(0, 0, 1, 7, 5);
        chk("b_oob_rel_cnt", b_cnt, 3);
        chk("b_oob_read_ru", b_ru, 0);
        chk("b_oob_read_rd", b_rd, 0);
        step_b(0, 0, 0, 0, 0);
        chk("b_oob_rel2_cnt", b_cnt, 3);
        chk("b_full", b_full, 0);
        chk("b_empty", b_empty, 0);
        chk("b_idx_after", b_idx, 1);

        // Asynchronous reset between clock edges
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_a_cnt", a_cnt, 0);
        chk("arst_a_empty", a_empty, 1);
        chk("arst_a_ready", a_rdy, 1);
        chk("arst_b_cnt", b_cnt, 0);
        chk("arst_b_empty", b_empty, 1);
        chk("arst_b_ready", b_rdy, 1);
        chk("arst_b_idx", b_idx, 4);
        for (int i = 0; i < 5; i++) begin
            b_rdi = 3'(i);
            #1;
            chk($sformatf("arst_b_ru%0d", i), b_ru, 0);
            chk($sformatf("arst_b_rd%0d", i), b_rd, 0);
        end
        for (int i = 0; i < 4; i++) begin
            a_rdi = 2'(i);
            #1;
            chk($sformatf("arst_a_ru%0d", i), a_ru, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
